// File: rtl/fpu_issue_controller.sv
// rtl/fpu_issue_controller.sv - single-outstanding issue sequencer between the execute stage and the fixed-point unit
module fpu_issue_controller #(
    parameter int WIDTH     = 32,
    parameter int FBITS     = 10,
    parameter int TAG_WIDTH = 5,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_operation,
    input  logic [WIDTH-1:0]     req_operand_1,
    input  logic [WIDTH-1:0]     req_operand_2,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic [1:0]           fpu_operation,
    output logic [WIDTH-1:0]     fpu_operand_1,
    output logic [WIDTH-1:0]     fpu_operand_2,
    output logic                 fpu_clear,
    input  logic [WIDTH-1:0]     fpu_result,
    input  logic                 fpu_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_result,
    output logic [TAG_WIDTH-1:0] rsp_tag,
    output logic                 rsp_error,
    output logic                 busy
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_SQRT = 2'd3;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    if (FBITS >= WIDTH) begin : g_bad_fbits
        $error("FBITS must be smaller than WIDTH");
    end

    typedef enum logic [1:0] {IDLE, CLEAR, EXEC, DONE} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        exec_cnt;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 accept, complete, expire;
    logic                 multi_req, multi_cur;

    assign multi_req = (req_operation == OP_MUL) || (req_operation == OP_SQRT);
    assign multi_cur = (fpu_operation == OP_MUL) || (fpu_operation == OP_SQRT);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        expire     = 1'b0;
        req_ready  = 1'b0;
        busy       = reset && (state != IDLE);
        fpu_clear  = !reset;
        case (state)
            IDLE: begin
                req_ready = reset;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = multi_req ? CLEAR : EXEC;
                end
            end
            CLEAR: begin
                fpu_clear  = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                // Sequenced ops still show the previous op's ready on their first EXEC cycle.
                if (fpu_ready && (!multi_cur || exec_cnt != '0)) begin
                    complete   = 1'b1;
                    state_next = DONE;
                end else if (exec_cnt == CNT_LAST) begin
                    expire     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            exec_cnt      <= '0;
            tag_q         <= '0;
            fpu_operation <= OP_ADD;
            fpu_operand_1 <= '0;
            fpu_operand_2 <= '0;
            rsp_valid     <= 1'b0;
            rsp_result    <= '0;
            rsp_tag       <= '0;
            rsp_error     <= 1'b0;
        end else begin
            if (accept) begin
                fpu_operation <= req_operation;
                fpu_operand_1 <= req_operand_1;
                fpu_operand_2 <= req_operand_2;
                tag_q         <= req_tag;
                exec_cnt      <= '0;
            end else if (state == EXEC) begin
                exec_cnt <= exec_cnt + 1'b1;
            end
            if (complete || expire) begin
                rsp_valid  <= 1'b1;
                rsp_result <= complete ? fpu_result : '0;
                rsp_error  <= expire;
                rsp_tag    <= tag_q;
            end else if (state == DONE && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule
